// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit for the EX stage.
// Executes mult/multu/div/divu over 32 iterations, owns HI/LO, executes
// mthi/mtlo, and requests a pipeline stall while an operation is in flight.
module ex_mdu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              op_valid,
    input  logic [5:0]        mdu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_for_mdu,
    output logic              busy
);

    localparam int W = DATA_W;

    // Stall vector encoding used by the pipeline controller
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_DIV   = 3'd1,
        K_DIVU  = 3'd2,
        K_MULT  = 3'd3,
        K_MULTU = 3'd4,
        K_MTHI  = 3'd5,
        K_MTLO  = 3'd6
    } kind_t;

    state_t         state_r;
    logic [5:0]     cnt_r;
    logic [W-1:0]   opnd_r;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*W-1:0] acc_r;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic           sign_q_r;
    logic           sign_r_r;
    logic           div0_r;
    logic [W-1:0]   raw_a_r;    // dividend as issued, returned in HI on divide by zero
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;

    kind_t          kind_s;
    logic           is_mul_s;
    logic           is_muldiv_s;
    logic           signed_op_s;
    logic           start_s;
    logic [W-1:0]   abs_a_s;
    logic [W-1:0]   abs_b_s;
    logic [W:0]     mul_sum_s;
    logic [2*W-1:0] mul_next_s;
    logic [2*W-1:0] prod_fix_s;
    logic [W:0]     div_shift_s;
    logic [W:0]     div_diff_s;
    logic           div_fits_s;
    logic [2*W-1:0] div_next_s;
    logic [W-1:0]   quo_fix_s;
    logic [W-1:0]   rem_fix_s;
    logic           unused_s;

    // Only the EX hold bit of the stall vector matters here
    assign unused_s = ^{stall[5:4], stall[2:0]};

    // Priority decode of the one-hot opcode: div > divu > mult > multu > mthi > mtlo
    always_comb begin
        kind_s = K_NONE;
        if (mdu_op[5]) begin
            kind_s = K_DIV;
        end else if (mdu_op[4]) begin
            kind_s = K_DIVU;
        end else if (mdu_op[3]) begin
            kind_s = K_MULT;
        end else if (mdu_op[2]) begin
            kind_s = K_MULTU;
        end else if (mdu_op[1]) begin
            kind_s = K_MTHI;
        end else if (mdu_op[0]) begin
            kind_s = K_MTLO;
        end else begin
            kind_s = K_NONE;
        end
    end

    // Issue qualification and operand magnitudes (|0x8000_0000| stays 0x8000_0000)
    always_comb begin
        is_mul_s    = (kind_s == K_MULT) || (kind_s == K_MULTU);
        is_muldiv_s = is_mul_s || (kind_s == K_DIV) || (kind_s == K_DIVU);
        signed_op_s = (kind_s == K_MULT) || (kind_s == K_DIV);
        start_s     = (state_r == S_IDLE) && op_valid && is_muldiv_s;
        abs_a_s     = (signed_op_s && src_a[W-1]) ? (~src_a + {{(W-1){1'b0}}, 1'b1}) : src_a;
        abs_b_s     = (signed_op_s && src_b[W-1]) ? (~src_b + {{(W-1){1'b0}}, 1'b1}) : src_b;
    end

    // One shift-add multiply step: add multiplicand if current multiplier bit is set, shift right
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[W-1:1]};
        prod_fix_s = sign_q_r ? (~mul_next_s + {{(2*W-1){1'b0}}, 1'b1}) : mul_next_s;
    end

    // One restoring divide step on a 33-bit partial remainder, quotient bit shifted in at the LSB
    always_comb begin
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        // A set top bit of the shifted remainder already exceeds any 32-bit divisor
        div_fits_s  = div_shift_s[W] | ~div_diff_s[W];
        if (div_fits_s) begin
            div_next_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
        end
        quo_fix_s = sign_q_r ? (~div_next_s[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : div_next_s[W-1:0];
        rem_fix_s = sign_r_r ? (~div_next_s[2*W-1:W] + {{(W-1){1'b0}}, 1'b1}) : div_next_s[2*W-1:W];
    end

    // Control FSM, iteration datapath and the architectural HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= 6'd0;
            opnd_r   <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            div0_r   <= 1'b0;
            raw_a_r  <= {W{1'b0}};
            hi_r     <= {W{1'b0}};
            lo_r     <= {W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        state_r  <= is_mul_s ? S_MUL : S_DIV;
                        cnt_r    <= 6'd0;
                        opnd_r   <= is_mul_s ? abs_a_s : abs_b_s;
                        acc_r    <= {{W{1'b0}}, (is_mul_s ? abs_b_s : abs_a_s)};
                        sign_q_r <= signed_op_s & (src_a[W-1] ^ src_b[W-1]);
                        sign_r_r <= signed_op_s & src_a[W-1];
                        div0_r   <= (src_b == {W{1'b0}});
                        raw_a_r  <= src_a;
                    end else if (op_valid && (stall[3] == NO_STOP)) begin
                        if (kind_s == K_MTHI) begin
                            hi_r <= src_a;
                        end else if (kind_s == K_MTLO) begin
                            lo_r <= src_a;
                        end else begin
                            hi_r <= hi_r;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_r <= mul_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        hi_r    <= prod_fix_s[2*W-1:W];
                        lo_r    <= prod_fix_s[W-1:0];
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_MUL;
                    end
                end
                S_DIV: begin
                    acc_r <= div_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        if (div0_r) begin
                            hi_r <= raw_a_r;
                            lo_r <= {W{1'b1}};
                        end else begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_DIV;
                    end
                end
                S_DONE: begin
                    // Hold here while EX is stalled so the same instruction cannot re-issue
                    if (stall[3] == STOP) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign hi_o             = hi_r;
    assign lo_o             = lo_r;
    assign stallreq_for_mdu = start_s || (state_r == S_MUL) || (state_r == S_DIV);
    assign busy             = (state_r != S_IDLE);

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It executes mult, multu, div and divu iteratively over 32 cycles, owns the architectural HI/LO registers and executes mthi/mtlo. While an operation is in flight it raises a stall request to the pipeline controller, and it exposes HI/LO to EX for mfhi/mflo. Its operands arrive already forwarded through the ID→EX bus.

## Interface
- DATA_W, 32: operand/HI/LO width; only 32 is supported.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  `StallBus` (6)  pipeline stall vector. Only stall[3] (EX hold) is used.
- op_valid  in  1  EX holds a valid instruction this cycle.
- mdu_op  in  6  one-hot {div, divu, mult, multu, mthi, mtlo}.
  - If more than one bit is set, priority is div > divu > mult > multu > mthi > mtlo.
- src_a  in  32  rs value; dividend, multiplicand, or mthi/mtlo data.
- src_b  in  32  rt value; divisor or multiplier.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.
- stallreq_for_mdu  out  1  request to stall IF..EX (`Stop`).
- busy  out  1  FSM is not IDLE.

## Operation
- State machine: IDLE, MUL, DIV, DONE. Encoding is free.
- IDLE + op_valid + div/divu/mult/multu:
  - latch |src_a| and |src_b| (plain values for unsigned ops);
  - latch sign_q = a[31]^b[31] and sign_r = a[31] (both 0 for unsigned ops);
  - clear the 6-bit iteration counter;
  - go to MUL or DIV.
- Magnitudes: |0x8000_0000| = 0x8000_0000 as an unsigned 32-bit value; no overflow.
- MUL: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- DIV: restoring division, one quotient bit per cycle, MSB first. Keep a 33-bit partial remainder for the subtract test.
- Counter: increments each MUL/DIV cycle. On counter == 31 the unit:
  - applies the sign fix-up;
  - writes HI/LO;
  - goes to DONE.
- Sign fix-up:
  - multiply: 64-bit product negated if sign_q; HI = product[63:32], LO = product[31:0].
  - divide: quotient negated if sign_q, remainder negated if sign_r; LO = quotient, HI = remainder.
- Divide by zero (src_b == 0): LO = 32'hFFFF_FFFF, HI = src_a as issued, with no sign fix-up. The unit still takes the full 32 iterations.
- DONE: op_valid/mdu_op are ignored. Stay while stall[3] == `Stop`; go to IDLE on the first cycle stall[3] == `NoStop`. This prevents the same instruction from re-issuing while it is held in EX.
- mthi/mtlo: in IDLE with op_valid and stall[3] == `NoStop`, write src_a to HI/LO at the clock edge. No state change and no stall.
- op_valid in MUL/DIV is ignored; EX is stalled, so it is the same instruction.
- hi_o/lo_o are driven directly from the registers, with no internal bypass.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0;
  - HI = LO = 0;
  - stallreq_for_mdu = 0, busy = 0;
  - all datapath registers = 0.
- Reset in MUL/DIV aborts the operation: HI/LO return to 0 and the stall drops in the same cycle.
- stallreq_for_mdu is combinational, asserted when:
  - (IDLE & op_valid & any of div/divu/mult/multu), or
  - state is MUL or DIV.
- Deasserted in IDLE (except at issue) and in DONE.
- Latency: issue in cycle T; iterations run in T+1..T+32; HI/LO updated at the edge ending T+32. In T+33 (DONE) the stall is low, so the instruction advances if nothing else stalls.
  - This gives 33 stalled cycles per mult/div.
- The first mfhi/mflo after a mult/div reaches EX at T+34 or later and reads the new value.
- mthi at cycle T: HI is updated at the edge ending T, so an mfhi in EX at T+1 reads the new value.
- busy = 1 in MUL, DIV and DONE.

## Test plan
- mult src_a = -3, src_b = 7 → HI = FFFF_FFFF, LO = FFFF_FFEB; stallreq high for exactly 33 cycles.
- divu 100 / 7 → LO = 0000_000E, HI = 0000_0002. div -7 / 2 → LO = FFFF_FFFD, HI = FFFF_FFFF.
- div 0x8000_0000 / 0xFFFF_FFFF → LO = 8000_0000, HI = 0. multu FFFF_FFFF × FFFF_FFFF → HI = FFFF_FFFE, LO = 0000_0001.
- divu 1234 / 0 → LO = FFFF_FFFF, HI = 0000_04D2 after 32 iterations. Hold stall[3] = `Stop` for 5 cycles in DONE → no re-issue; HI/LO unchanged.
- mthi 0xDEAD_BEEF, then mtlo 0x1234 on the next cycle → hi_o = DEAD_BEEF after the first edge, lo_o = 0000_1234 after the second; stallreq never asserted.
- Start div, assert rst at iteration 10 → stallreq/busy drop immediately, HI = LO = 0. After reset release, a new divu 9 / 3 → LO = 3, HI = 0.
